regfile_dump_reader: RTL

//  Sequential reader for the CPU register file's read port. On a start pulse it walks register indices

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/regfile_dump_reader_if.sv | 27 ++
 rtl/regfile_dump_reader_out_buf.sv | 42 ++++
 rtl/regfile_dump_reader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU widths, dump FSM states and the dump beat layout.
// Imported by the dump reader, its output buffer and its stream interface.
package cpu_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int WORD_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [WORD_W-1:0]     word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } dump_state_e;

   typedef struct packed {
      word_t    data;
      reg_idx_t index;
      logic     last;
   } dump_beat_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Dump output stream: valid/ready handshake carrying data, register index and last flag.
// master drives the beat, slave returns ready.
interface regfile_dump_reader_if;
   import cpu_pkg::*;

   logic     out_valid;
   logic     out_ready;
   word_t    out_data;
   reg_idx_t out_index;
   logic     out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/regfile_dump_reader_out_buf.sv
// One-entry output holding register; a load is taken when empty or when the held beat transfers.
// Zero added latency beyond the register; the held beat stays stable while ready is low.
module regdump_out_buf
   import cpu_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       load_vld_i,
   input  dump_beat_t load_dat_i,
   input  logic       out_ready_i,
   output logic       out_valid_o,
   output dump_beat_t out_dat_o
);

   logic       valid_q, valid_d;
   dump_beat_t beat_q, beat_d;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (load_vld_i && (!valid_q || out_ready_i)) begin
         valid_d = 1'b1;
         beat_d  = load_dat_i;
      end else if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_dat_o   = beat_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks FIRST_REG..LAST_REG on start and streams each read word; first beat valid one edge after FETCH, then 1 word/cycle.
// Stalls hold the beat and rf_addr; REGDUMP_CHECKSUM_EN appends an XOR checksum beat (index 0) as the last beat.
module regfile_dump_reader
   import cpu_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   output reg_idx_t              rf_addr_o,
   input  word_t                 rf_data_i,
   regfile_dump_reader_if.master out_if,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST_REG);
   localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST_REG);

   dump_state_e state_q, state_d;
   reg_idx_t    idx_q, idx_d;
   logic        load_vld;
   logic        capture;
   dump_beat_t  load_beat;
   logic        buf_valid;
   dump_beat_t  buf_beat;
   logic        hs;
   logic        at_last;

`ifdef REGDUMP_CHECKSUM_EN
   word_t csum_q, csum_d;
   logic  rf_done_q, rf_done_d;
`endif

   assign hs      = buf_valid && out_if.out_ready;
   assign at_last = (idx_q == LAST_IDX);

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      load_vld        = 1'b0;
      capture         = 1'b0;
      load_beat.data  = rf_data_i;
      load_beat.index = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
      load_beat.last  = 1'b0;
      csum_d          = csum_q;
      rf_done_d       = rf_done_q;
`else
      load_beat.last  = at_last;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = FETCH;
               idx_d   = FIRST_IDX;
`ifdef REGDUMP_CHECKSUM_EN
               csum_d    = '0;
               rf_done_d = 1'b0;
`endif
            end
         end
         FETCH: begin
            capture = 1'b1;
            state_d = STREAM;
         end
         STREAM: begin
            if (hs) begin
               if (buf_beat.last) begin
                  state_d = DONE;
`ifdef REGDUMP_CHECKSUM_EN
               end else if (rf_done_q) begin
                  load_vld        = 1'b1;
                  load_beat.data  = csum_q;
                  load_beat.index = '0;
                  load_beat.last  = 1'b1;
`endif
               end else begin
                  capture = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
         end
         default: state_d = IDLE;
      endcase
      // Index saturates at LAST_REG: no wrap past the final register.
      if (capture) begin
         load_vld = 1'b1;
         if (!at_last) begin
            idx_d = idx_q + reg_idx_t'(1);
         end
`ifdef REGDUMP_CHECKSUM_EN
         csum_d    = csum_q ^ rf_data_i;
         rf_done_d = at_last;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= FIRST_IDX;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

`ifdef REGDUMP_CHECKSUM_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         csum_q    <= '0;
         rf_done_q <= 1'b0;
      end else begin
         csum_q    <= csum_d;
         rf_done_q <= rf_done_d;
      end
   end
`endif

   regdump_out_buf u_out_buf (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_vld_i  (load_vld),
      .load_dat_i  (load_beat),
      .out_ready_i (out_if.out_ready),
      .out_valid_o (buf_valid),
      .out_dat_o   (buf_beat)
   );

   assign out_if.out_valid = buf_valid;
   assign out_if.out_data  = buf_beat.data;
   assign out_if.out_index = buf_beat.index;
   assign out_if.out_last  = buf_beat.last;

   assign rf_addr_o = idx_q;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);

endmodule
